// File: rtl/decoder_n_scan_if.sv
// Bus bundle for decoder_n_scan: control/select inputs and registered decode outputs.
interface decoder_n_scan_if #(
    parameter int unsigned N = 2
) ();
    logic              e;
    logic              mode;
    logic [N-1:0]      I;
    logic [(1<<N)-1:0] y;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (output e, mode, I, input y, idx, wrap);
    modport slave  (input e, mode, I, output y, idx, wrap);
endinterface

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with a direct mode and a self-timed scan mode
// that strobes each line for DWELL cycles and pulses wrap when the walk returns to line 0.
module decoder_n_scan #(
    parameter int unsigned N          = 2,
    parameter int unsigned DWELL      = 4,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    decoder_n_scan_if.slave   bus
);
    localparam int unsigned W    = 1 << N;
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(DWELL - 1);
    localparam logic [W-1:0]    Inactive = {W{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {StOff, StDirect, StScan} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic            wrap_q, wrap_d;
    logic [W-1:0]    onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= Inactive;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        wrap_d  = 1'b0;
        if (!bus.e) begin
            state_d = StOff;
        end else if (!bus.mode) begin
            state_d = StDirect;
            idx_d   = bus.I;
        end else if (state_q != StScan) begin
            // Scan entry: load start line, dwell restarts from 0.
            state_d = StScan;
            idx_d   = bus.I;
        end else if (cnt_q == CntLast) begin
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == {N{1'b1}});
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        onehot = W'(1) << idx_d;
        if (state_d == StOff) begin
            y_d = Inactive;
        end else begin
            y_d = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule
